multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: a Moore FSM whose control outputs are
// decoded from the registered state (plus memReady in FETCH, and opcode for
// the illegal-instruction pulse in DECODE).
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       memtoReg,
    output logic       regWrite,
    output logic       regDst,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDIEXEC = 4'd11,
        S_ADDIWB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;

    // Next-state selection; unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = memReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; async reset parks the FSM in IDLE so every output drops at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Moore output decode; anything not driven in a state stays 0
    always_comb begin
        memtoReg    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegalOp = 1'b0;
                    default:                                       illegalOp = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMREAD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcSource    = 2'b01;
                pcWriteCond = 1'b1;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_ADDIWB: regWrite = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a
// randomized run, all checked against an instruction-path model.
module tb_multicycle_control;

    logic       clock, reset, memReady;
    logic [5:0] opcode;
    logic       memtoReg, regWrite, regDst, memRead, memWrite, iorD, irWrite;
    logic       pcWrite, pcWriteCond, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .memReady(memReady),
        .memtoReg(memtoReg), .regWrite(regWrite), .regDst(regDst),
        .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .illegalOp(illegalOp), .state(state)
    );

    wire [16:0] ctrl = {memtoReg, regWrite, regDst, memRead, memWrite, iorD, irWrite,
                        pcWrite, pcWriteCond, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: current expected state plus the remaining state path of the
    // instruction in flight, derived from its opcode when it is decoded.
    logic [3:0] exp_st;
    logic [3:0] pend[$];

    task automatic load_path(input logic [5:0] op);
        pend.delete();
        case (op)
            6'b100011: begin pend.push_back(4'd3); pend.push_back(4'd4); pend.push_back(4'd5); end
            6'b101011: begin pend.push_back(4'd3); pend.push_back(4'd6); end
            6'b000000: begin pend.push_back(4'd7); pend.push_back(4'd8); end
            6'b000100: pend.push_back(4'd9);
            6'b000010: pend.push_back(4'd10);
            6'b001000: begin pend.push_back(4'd11); pend.push_back(4'd12); end
            default: ;
        endcase
    endtask

    task automatic model_step;
        if ((exp_st == 4'd1 || exp_st == 4'd4 || exp_st == 4'd6) && !memReady) return;
        if (exp_st == 4'd0)      exp_st = 4'd1;
        else if (exp_st == 4'd1) exp_st = 4'd2;
        else begin
            if (exp_st == 4'd2) load_path(opcode);
            if (pend.size() > 0) exp_st = pend.pop_front();
            else                 exp_st = 4'd1;
        end
    endtask

    // Expected control word for a state, straight from the output table
    function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic mr, input logic [5:0] op);
        logic mtr, rw, rd, mrd, mwr, iord, irw, pcw, pcwc, asa, ill;
        logic [1:0] asb, aop, psrc;
        {mtr, rw, rd, mrd, mwr, iord, irw, pcw, pcwc, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (s)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  begin asb = 2'b11;
                         ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000}); end
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; mtr = 1; end
            4'd6:  begin mwr = 1; iord = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; end
            4'd10: begin pcw = 1; psrc = 2'b10; end
            4'd11: begin asa = 1; asb = 2'b10; end
            4'd12: rw = 1;
            default: ;
        endcase
        return {mtr, rw, rd, mrd, mwr, iord, irw, pcw, pcwc, asa, asb, aop, psrc, ill};
    endfunction

    task automatic tick;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; memReady = 1'b1; opcode = 6'b000000;
        exp_st = 4'd0; pend.delete();
        for (int c = 0; c < 3; c++) begin
            #7;
            n_tests++;
            if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
            n_tests++;
            if (ctrl !== 17'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", ctrl); end
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_rtype;
        logic [3:0] seq[6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        opcode = 6'b000000; memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if (state !== seq[i]) begin n_fail++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", i, state, seq[i]); end
            n_tests++;
            if (ctrl !== exp_ctrl(exp_st, memReady, opcode)) begin
                n_fail++; $display("FAIL rtype_ctrl cyc=%0d got=%h exp=%h", i, ctrl, exp_ctrl(exp_st, memReady, opcode)); end
            n_tests++;
            if (regWrite !== (seq[i] == 4'd8)) begin n_fail++; $display("FAIL rtype_regwrite cyc=%0d got=%b", i, regWrite); end
            if (i == 5) break;
            tick();
        end
    endtask

    task automatic test_lw_wait;
        int waits = 0;
        int held = 0;
        opcode = 6'b100011;
        for (int c = 0; c < 20; c++) begin
            memReady = !(exp_st == 4'd4 && waits < 3);
            if (exp_st == 4'd4 && waits < 3) waits++;
            #1;
            if (state == 4'd4 && !memReady) held++;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            n_tests++;
            if (ctrl !== exp_ctrl(exp_st, memReady, opcode)) begin
                n_fail++; $display("FAIL lw_ctrl cyc=%0d got=%h exp=%h", c, ctrl, exp_ctrl(exp_st, memReady, opcode)); end
            if (c > 0 && exp_st == 4'd1) break;
            tick();
        end
        n_tests++;
        if (held !== 3) begin n_fail++; $display("FAIL lw_hold got=%0d exp=3", held); end
    endtask

    task automatic test_sw;
        opcode = 6'b101011; memReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            n_tests++;
            if (memWrite !== (exp_st == 4'd6) || regWrite !== 1'b0) begin
                n_fail++; $display("FAIL sw_enables cyc=%0d memWrite=%b regWrite=%b", c, memWrite, regWrite); end
            if (c > 0 && exp_st == 4'd1) break;
            tick();
        end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111; memReady = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL illegal_state cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            n_tests++;
            if (illegalOp !== (exp_st == 4'd2)) begin n_fail++; $display("FAIL illegal_pulse cyc=%0d got=%b", c, illegalOp); end
            if (exp_st == 4'd2) begin
                n_tests++;
                if ({regWrite, memWrite, pcWrite, pcWriteCond, irWrite} !== 5'b0) begin
                    n_fail++; $display("FAIL illegal_writes got=%b exp=00000", {regWrite, memWrite, pcWrite, pcWriteCond, irWrite}); end
            end
            if (c > 0 && exp_st == 4'd1) break;
            tick();
        end
    endtask

    task automatic test_fetch_wait;
        opcode = 6'b000010;
        for (int c = 0; c < 10; c++) begin
            memReady = (c >= 2);
            #1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL fwait_state cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            n_tests++;
            if (irWrite !== (exp_st == 4'd1 && memReady) || pcWrite !== ((exp_st == 4'd1 && memReady) || exp_st == 4'd10)) begin
                n_fail++; $display("FAIL fwait_irpc cyc=%0d irWrite=%b pcWrite=%b", c, irWrite, pcWrite); end
            if (c > 2 && exp_st == 4'd1) break;
            tick();
        end
    endtask

    task automatic test_async_reset;
        bit in6 = 0;
        opcode = 6'b101011;
        for (int c = 0; c < 10; c++) begin
            memReady = (exp_st != 4'd6);
            #1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL areset_pre cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            if (exp_st == 4'd6 && in6) break;
            if (exp_st == 4'd6) in6 = 1;
            tick();
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || memWrite !== 1'b0) begin
            n_fail++; $display("FAIL areset_now state=%0d memWrite=%b exp state=0 memWrite=0", state, memWrite); end
        n_tests++;
        if (ctrl !== 17'd0) begin n_fail++; $display("FAIL areset_outputs got=%h exp=0", ctrl); end
        #1 reset = 1'b1;
        exp_st = 4'd0; pend.delete(); memReady = 1'b1;
        tick();
        n_tests++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL areset_recover got=%0d exp=1", state); end
    endtask

    task automatic test_random;
        logic [5:0] pool[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        for (int c = 0; c < 400; c++) begin
            if (exp_st == 4'd1) begin
                int r = $urandom_range(0, 6);
                opcode = (r == 6) ? 6'($urandom) : pool[r];
            end
            memReady = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", c, state, exp_st); end
            n_tests++;
            if (ctrl !== exp_ctrl(exp_st, memReady, opcode)) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", c, ctrl, exp_ctrl(exp_st, memReady, opcode)); end
            n_tests++;
            if ((regWrite && memWrite) || (memtoReg && exp_st != 4'd5)) begin
                n_fail++; $display("FAIL rand_exclusive cyc=%0d regWrite=%b memWrite=%b memtoReg=%b", c, regWrite, memWrite, memtoReg); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_illegal();
        test_fetch_wait();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
